// File: rtl/alu_mult_seq_if.sv
// alu_mult_seq_if: requester handshake and shared-ALU bus for the sequential multiplier.
//   master: requester/ALU side (drives start, op_a, op_b, alu_r, alu_cout)
//   slave : multiplier side    (drives busy, done, product, alu_a, alu_b, alu_op, alu_cin)
interface alu_mult_seq_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic [WIDTH-1:0]       op_a;
    logic [WIDTH-1:0]       op_b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;
    logic [WIDTH-1:0]       alu_a;
    logic [WIDTH-1:0]       alu_b;
    logic [2:0]             alu_op;
    logic                   alu_cin;
    logic [WIDTH-1:0]       alu_r;
    logic                   alu_cout;

    modport master (
        output start, op_a, op_b, alu_r, alu_cout,
        input  busy, done, product, alu_a, alu_b, alu_op, alu_cin
    );

    modport slave (
        input  start, op_a, op_b, alu_r, alu_cout,
        output busy, done, product, alu_a, alu_b, alu_op, alu_cin
    );
endinterface

// File: rtl/alu_mult_seq.sv
// alu_mult_seq: unsigned shift-add multiplier that sequences an external combinational ALU.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of alu_mult_seq_if (start/op_a/op_b in, busy/done/product out,
//           alu_a/alu_b/alu_op/alu_cin to the ALU, alu_r/alu_cout from the ALU)
module alu_mult_seq #(
    parameter int         WIDTH  = 32,
    parameter logic [2:0] ADD_OP = 3'b010
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_mult_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_m;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_q;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_product;
    logic                 w_last;
    logic [WIDTH-1:0]     w_acc_nxt;
    logic [WIDTH-1:0]     w_q_nxt;

    assign w_last    = r_cnt == CW'(WIDTH - 1);
    // {carry, sum} shifted right by one: sum LSB drops into the multiplier register
    assign w_acc_nxt = {bus.alu_cout, bus.alu_r[WIDTH-1:1]};
    assign w_q_nxt   = {bus.alu_r[0], r_q[WIDTH-1:1]};

    assign bus.busy    = r_state != S_IDLE;
    assign bus.done    = r_state == S_DONE;
    assign bus.product = r_product;
    assign bus.alu_a   = r_acc;
    assign bus.alu_b   = r_q[0] ? r_m : '0;
    assign bus.alu_op  = ADD_OP;
    assign bus.alu_cin = 1'b0;

    always_comb begin
        w_next = r_state;
        w_next = (r_state == S_IDLE) ? (bus.start ? S_RUN : S_IDLE) :
                 (r_state == S_RUN)  ? (w_last ? S_DONE : S_RUN) : S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // product is captured on the last RUN edge so it is valid while done is high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_m       <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_m   <= bus.op_a;
            r_q   <= bus.op_b;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) r_product <= {w_acc_nxt, w_q_nxt};
        end
    end
endmodule

// File: tb/tb_alu_mult_seq.sv
// tb_alu_mult_seq: directed checks of alu_mult_seq at WIDTH=8 and WIDTH=32 with a behavioural ALU.
module tb_alu_mult_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_mult_seq_if #(.WIDTH(8))  s8 ();
    alu_mult_seq_if #(.WIDTH(32)) s32 ();

    // combinational ripple ALU stand-ins: {c_out, r} = a + b + c_in
    assign {s8.alu_cout, s8.alu_r}   = 9'(s8.alu_a) + 9'(s8.alu_b) + 9'(s8.alu_cin);
    assign {s32.alu_cout, s32.alu_r} = 33'(s32.alu_a) + 33'(s32.alu_b) + 33'(s32.alu_cin);

    alu_mult_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(s8.slave));
    alu_mult_seq #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(s32.slave));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // start is accepted at the first edge; lat counts cycles after that edge until done
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit hold,
                        output int lat, output int nbusy, output bit cout_seen, output bit bnz_seen);
        s8.start = 1'b1;
        s8.op_a  = a;
        s8.op_b  = b;
        @(posedge clk); #1;
        if (hold) begin
            s8.op_a = 8'd2;
            s8.op_b = 8'd2;
        end else s8.start = 1'b0;
        lat = 1;
        nbusy = 0;
        cout_seen = 1'b0;
        bnz_seen = 1'b0;
        while (!s8.done && lat < 50) begin
            nbusy += int'(s8.busy);
            cout_seen |= s8.alu_cout;
            bnz_seen |= (s8.alu_b != 8'd0);
            @(posedge clk); #1;
            lat++;
        end
        nbusy += int'(s8.busy);
    endtask

    int lat, nbusy, seen_done;
    bit cs, bs;

    initial begin
        s8.start = 1'b0;  s8.op_a = '0;  s8.op_b = '0;
        s32.start = 1'b0; s32.op_a = '0; s32.op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(s8.busy), 64'd0);
        chk("rst_done", 64'(s8.done), 64'd0);
        chk("rst_product", 64'(s8.product), 64'd0);
        chk("rst_alu_a", 64'(s8.alu_a), 64'd0);
        chk("rst_alu_b", 64'(s8.alu_b), 64'd0);
        chk("alu_op", 64'(s8.alu_op), 64'd2);
        chk("alu_cin", 64'(s8.alu_cin), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run8(8'd3, 8'd5, 1'b0, lat, nbusy, cs, bs);
        chk("3x5_latency", 64'(lat), 64'd9);
        chk("3x5_busy_cycles", 64'(nbusy), 64'd9);
        chk("3x5_product", 64'(s8.product), 64'd15);
        @(posedge clk); #1;
        chk("3x5_done_pulse", 64'(s8.done), 64'd0);
        chk("3x5_idle", 64'(s8.busy), 64'd0);
        chk("3x5_product_hold", 64'(s8.product), 64'd15);

        run8(8'hFF, 8'hFF, 1'b0, lat, nbusy, cs, bs);
        chk("ffxff_product", 64'(s8.product), 64'hFE01);
        chk("ffxff_cout_seen", 64'(cs), 64'd1);
        @(posedge clk); #1;

        run8(8'd0, 8'hA5, 1'b0, lat, nbusy, cs, bs);
        chk("0xa5_latency", 64'(lat), 64'd9);
        chk("0xa5_product", 64'(s8.product), 64'd0);
        chk("0xa5_alu_b_zero", 64'(bs), 64'd0);
        @(posedge clk); #1;

        // start held high through RUN and DONE with new operands 2,2
        run8(8'd7, 8'd9, 1'b1, lat, nbusy, cs, bs);
        chk("7x9_latency", 64'(lat), 64'd9);
        chk("7x9_product", 64'(s8.product), 64'd63);
        @(posedge clk); #1;
        chk("start_in_done_ignored", 64'(s8.busy), 64'd0);
        chk("7x9_product_hold", 64'(s8.product), 64'd63);
        @(posedge clk); #1;
        chk("start_in_idle_accepted", 64'(s8.busy), 64'd1);
        s8.start = 1'b0;
        lat = 1;
        while (!s8.done && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("2x2_latency", 64'(lat), 64'd9);
        chk("2x2_product", 64'(s8.product), 64'd4);
        @(posedge clk); #1;

        // reset during RUN cycle 4
        s8.start = 1'b1; s8.op_a = 8'd7; s8.op_b = 8'd9;
        @(posedge clk); #1;
        s8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_busy", 64'(s8.busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrun_rst_busy", 64'(s8.busy), 64'd0);
        chk("midrun_rst_product", 64'(s8.product), 64'd0);
        chk("midrun_rst_alu_a", 64'(s8.alu_a), 64'd0);
        chk("midrun_rst_alu_b", 64'(s8.alu_b), 64'd0);
        seen_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            seen_done += int'(s8.done);
        end
        chk("midrun_rst_no_done", 64'(seen_done), 64'd0);
        run8(8'd10, 8'd10, 1'b0, lat, nbusy, cs, bs);
        chk("10x10_product", 64'(s8.product), 64'd100);
        @(posedge clk); #1;

        s32.start = 1'b1; s32.op_a = 32'hFFFF_FFFF; s32.op_b = 32'd2;
        @(posedge clk); #1;
        s32.start = 1'b0;
        lat = 1;
        while (!s32.done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w32_latency", 64'(lat), 64'd33);
        chk("w32_product", s32.product, 64'h1_FFFF_FFFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
